// File: rtl/brqrv_gpio_bridge.sv
// GPIO bridge from the BrqRV_EB1 peripheral bus to the Caravel mprj_io pads.
// Paces result bytes onto the pads, sequences the ready flag and synchronizes host inputs.
module brqrv_gpio_bridge #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned READY_DELAY = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RdyW  = $clog2(READY_DELAY + 1);

  localparam logic StIdle = 1'b0;
  localparam logic StHold = 1'b1;

  localparam logic [1:0] AddrTx     = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrInput  = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            pushed_q;
  logic            state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [7:0]      disp_q;
  logic [RdyW-1:0] rdy_cnt_q;
  logic            ready_en_q, ready_q;
  logic [18:0]     sync1_q, sync2_q;
  logic            ack_q;
  logic [31:0]     rdata_q;

  logic        fifo_empty, fifo_full, hold_done, pop, push, accept, rdy_done;
  logic [31:0] status_word, rd_word;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
  assign hold_done  = (state_q == StIdle) || (hold_cnt_q == '0);
  // A byte pushed on the previous edge is not yet poppable: pads follow a push by two edges.
  assign pop        = (level_q > LvlW'(pushed_q)) && hold_done;
  assign accept     = bus_req && !ack_q &&
                      !(bus_we && (bus_addr[3:2] == AddrTx) && fifo_full && !pop);
  assign push       = accept && bus_we && (bus_addr[3:2] == AddrTx);
  assign rdy_done   = (rdy_cnt_q == RdyW'(READY_DELAY));

  always_comb begin
    status_word            = '0;
    status_word[3:0]       = {state_q == StHold, ready_q, fifo_full, fifo_empty};
    status_word[4 +: LvlW] = level_q;
    rd_word = '0;
    unique case (bus_addr[3:2])
      AddrStatus: rd_word = status_word;
      AddrInput:  rd_word = {13'b0, sync2_q};
      AddrCtrl:   rd_word = {31'b0, ready_en_q};
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus_wdata[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      pushed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      disp_q     <= '0;
      rdy_cnt_q  <= '0;
      ready_en_q <= 1'b0;
      ready_q    <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      ack_q    <= accept;
      rdata_q  <= (accept && !bus_we) ? rd_word : '0;
      pushed_q <= push;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);

      if (pop) begin
        disp_q     <= fifo_mem[rd_ptr_q];
        state_q    <= StHold;
        hold_cnt_q <= HoldW'(HOLD_CYCLES - 1);
      end else if (state_q == StHold) begin
        if (hold_cnt_q == '0) state_q <= StIdle;
        else                  hold_cnt_q <= hold_cnt_q - HoldW'(1);
      end

      if (!rdy_done) rdy_cnt_q <= rdy_cnt_q + RdyW'(1);
      ready_q <= rdy_done && ready_en_q;
      if (accept && bus_we && (bus_addr[3:2] == AddrCtrl)) ready_en_q <= bus_wdata[0];

      sync1_q <= io_in[26:8];
      sync2_q <= sync1_q;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;
  assign io_out    = {ready_q, 2'b00, disp_q, 27'b0};
  assign io_oeb    = {1'b0, 2'b11, 8'h00, {27{1'b1}}};

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8], io_in[37:27], io_in[7:0]};

endmodule

// File: tb/tb_brqrv_gpio_bridge.sv
// Bench for brqrv_gpio_bridge: directed scenarios plus random bus traffic, all checked
// against a queue-based model evaluated every cycle.
module tb_brqrv_gpio_bridge;

  localparam int DEPTH = 4;
  localparam int HOLD  = 16;
  localparam int DELAY = 64;
  localparam logic [37:0] OEB_EXP = 38'h18_07FF_FFFF;

  logic        clk, rst;
  logic        req, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack;
  logic [37:0] io_in, io_out, io_oeb;

  brqrv_gpio_bridge #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_CYCLES(HOLD),
    .READY_DELAY(DELAY)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus_req  (req),
    .bus_we   (we),
    .bus_addr (addr),
    .bus_wdata(wdata),
    .bus_rdata(rdata),
    .bus_ack  (ack),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, display timing from the edge number of the last pop.
  logic [7:0]  mq[$];
  int          cyc = 0;
  int          m_last;
  bit          m_pushed, m_rpad, m_en, m_ack, model_on = 0;
  int          m_rdy;
  logic [7:0]  m_disp;
  logic [31:0] m_rdata;
  logic [18:0] m_s1, m_s2;

  always @(posedge clk) begin
    int e, avail, sti;
    bit pop, acc, tx;
    logic [31:0] rd;
    if (rst) begin
      mq.delete();
      m_last = -100000; m_pushed = 0; m_disp = 8'h00; m_rpad = 0; m_en = 0; m_rdy = 0;
      m_ack = 0; m_rdata = 0; m_s1 = 0; m_s2 = 0; cyc = 0; model_on = 1;
    end else begin
      e     = cyc + 1;
      avail = mq.size() - (m_pushed ? 1 : 0);
      pop   = (avail > 0) && ((e - m_last) >= HOLD);
      tx    = (addr[3:2] == 2'd0);
      acc   = req && !m_ack && !(we && tx && (mq.size() == DEPTH) && !pop);
      sti   = mq.size() * 16 + (((e - m_last) <= HOLD) ? 8 : 0) + (m_rpad ? 4 : 0)
              + ((mq.size() == DEPTH) ? 2 : 0) + ((mq.size() == 0) ? 1 : 0);
      case (addr[3:2])
        2'd1:    rd = 32'(sti);
        2'd2:    rd = {13'b0, m_s2};
        2'd3:    rd = {31'b0, m_en};
        default: rd = 32'h0;
      endcase
      m_rdata = (acc && !we) ? rd : 32'h0;
      m_ack   = acc;
      m_rpad  = (m_rdy == DELAY) && m_en;
      if (m_rdy < DELAY) m_rdy++;
      if (acc && we && addr[3:2] == 2'd3) m_en = wdata[0];
      if (pop) begin
        m_disp = mq.pop_front();
        m_last = e;
      end
      m_pushed = acc && we && tx;
      if (m_pushed) mq.push_back(wdata[7:0]);
      m_s2 = m_s1;
      m_s1 = io_in[26:8];
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ack", ack, m_ack);
      check("rdata", rdata, m_rdata);
      check("io_out", io_out, {m_rpad, 2'b00, m_disp, 27'b0});
      check("io_oeb", io_oeb, OEB_EXP);
    end
  end

  logic [7:0] pad_before, ack_pad, ack_pad_prev;

  // Caller is at a negedge; returns at a negedge with req having been low for one edge.
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] r, output int waits);
    req = 1'b1; we = w; addr = a; wdata = d; waits = 0;
    do begin
      pad_before = io_out[34:27];
      @(negedge clk);
      waits++;
    end while (!ack && waits < 300);
    if (!ack) check("bus_timeout", ack, 1);
    ack_pad      = io_out[34:27];
    ack_pad_prev = pad_before;
    r = rdata;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("wait_cyc", cyc, n);
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] rnd;
    logic [3:0]  a;
    int          w;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0; io_in = 38'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_io_out", io_out, 38'h0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 32'h0);

    // Ready sequencing: CTRL written at edge 10, pad rises at edge 65.
    wait_until(9);
    bus(1'b1, 4'hC, 32'h1, r, w);
    wait_until(64);
    check("rdy_before", io_out[37], 0);
    @(negedge clk);
    check("rdy_after", io_out[37], 1);
    bus(1'b0, 4'h4, 32'h0, r, w);
    check("status_rdy", r, 32'h05);
    bus(1'b0, 4'hC, 32'h0, r, w);
    check("ctrl_rd", r, 32'h1);

    // Back-to-back bytes: one in display plus a full FIFO, so the sixth write onward stalls.
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, 4'h0, 32'(i), r, w);
      check("tx_stall", 64'(w > 1), 64'(i >= 5));
    end
    repeat (120) @(negedge clk);
    check("last_byte", io_out[34:27], 8'h08);
    bus(1'b0, 4'h4, 32'h0, r, w);
    check("status_idle", r, 32'h05);

    // Full FIFO behind a busy display; fifth write acks with the freeing pop.
    bus(1'b1, 4'hC, 32'h0, r, w);
    bus(1'b1, 4'h0, 32'hA0, r, w);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) bus(1'b1, 4'h0, 32'hA0 + 32'(i), r, w);
    bus(1'b0, 4'h4, 32'h0, r, w);
    check("status_full", r, 32'h4A);
    bus(1'b1, 4'h0, 32'hA5, r, w);
    check("full_stalled", 64'(w > 1), 1);
    check("full_pad_prev", ack_pad_prev, 8'hA0);
    check("full_pad_ack", ack_pad, 8'hA1);
    repeat (100) @(negedge clk);

    // Input synchronizer.
    rnd = {$urandom, $urandom};
    io_in = {rnd[10:0], 16'h1234, 3'b110, rnd[18:11]};
    @(negedge clk);
    bus(1'b0, 4'h8, 32'h0, r, w);
    check("input_old", r, 32'h0);
    bus(1'b0, 4'h8, 32'h0, r, w);
    check("input_new", r, 32'h91A6);
    io_in = 38'h0;

    // Reset while 0x99 is displayed with three bytes queued.
    bus(1'b1, 4'hC, 32'h1, r, w);
    bus(1'b1, 4'h0, 32'h99, r, w);
    repeat (3) @(negedge clk);
    bus(1'b1, 4'h0, 32'h11, r, w);
    bus(1'b1, 4'h0, 32'h22, r, w);
    bus(1'b1, 4'h0, 32'h33, r, w);
    check("hold_99", io_out[34:27], 8'h99);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_io", io_out, 38'h0);
    rst = 1'b0;
    bus(1'b0, 4'h4, 32'h0, r, w);
    check("rst_mid_status", r, 32'h01);
    bus(1'b1, 4'hC, 32'h1, r, w);
    wait_until(64);
    check("rdy2_before", io_out[37], 0);
    @(negedge clk);
    check("rdy2_after", io_out[37], 1);

    // Single byte into an empty FIFO.
    bus(1'b1, 4'h0, 32'h99, r, w);
    check("single_ack_pad", ack_pad, 8'h00);
    check("single_mid_pad", io_out[34:27], 8'h00);
    @(negedge clk);
    check("single_pad", io_out[34:27], 8'h99);
    repeat (20) @(negedge clk);
    bus(1'b0, 4'h4, 32'h0, r, w);
    check("single_idle_status", r, 32'h05);
    check("single_persist", io_out[34:27], 8'h99);

    // Random traffic, inputs and occasional resets, checked by the model.
    for (int k = 0; k < 250; k++) begin
      rnd = {$urandom, $urandom};
      io_in = rnd[37:0];
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a[3:2] = 2'd0;
      bus(1'($urandom_range(0, 1)), a, $urandom, r, w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
